// File: rtl/hash_seq.sv
// Hash job sequencer: configures the hash core, streams key/message blocks with
// zero padding and block framing, then forwards the digest bytes.
module hash_seq #(
    parameter int unsigned MAX_LL  = 65535,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_async,
    input  logic        start_i,
    input  logic [5:0]  key_len_i,
    input  logic [5:0]  hash_len_i,
    input  logic [15:0] msg_len_i,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic [7:0]  core_data_o,
    output logic [2:0]  core_ctrl_o,
    input  logic        core_ready_i,
    input  logic        core_hash_v_i,
    input  logic [7:0]  core_hash_i,
    output logic [7:0]  m_data_o,
    output logic        m_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {StIdle, StCfg, StBlock, StPad, StHash} state_e;

    localparam logic [1:0] CmdCfg   = 2'b00;
    localparam logic [1:0] CmdFirst = 2'b01;
    localparam logic [1:0] CmdData  = 2'b10;
    localparam logic [1:0] CmdLast  = 2'b11;

    state_e      state_q;
    logic [5:0]  kk_q, nn_q, byte_cnt_q, hash_cnt_q;
    logic [15:0] ll_q, blk_cnt_q, msg_rem_q, stall_q;
    logic        key_blk_q;
    logic [7:0]  m_data_q;
    logic        m_valid_q, done_q, err_q;

    logic [1:0]  blk_cmd;
    logic        core_xfer, hash_take, bad_cfg, in_block_src, next_blk_src;
    logic [6:0]  byte_nxt;
    logic [15:0] msg_rem_nxt, nb;
    logic [10:0] msg_blks;

    assign bad_cfg = (key_len_i > 6'd32) || (hash_len_i == 6'd0) || (hash_len_i > 6'd32)
                     || (32'(msg_len_i) > MAX_LL);

    // A zero-length job still sends one (all-padding) block.
    assign msg_blks = {1'b0, ll_q[15:6]} + 11'(ll_q[5:0] != 6'd0);
    always_comb begin
        nb = 16'(msg_blks) + 16'(kk_q != 6'd0);
        if (nb == 16'd0) nb = 16'd1;
    end

    assign blk_cmd = (byte_cnt_q == 6'd0) ? CmdFirst :
                     (blk_cnt_q == 16'd1) ? CmdLast : CmdData;

    always_comb begin
        core_data_o = 8'h00;
        core_ctrl_o = 3'b000;
        s_ready_o   = 1'b0;
        unique case (state_q)
            StCfg: begin
                core_ctrl_o = {CmdCfg, 1'b1};
                unique case (byte_cnt_q[1:0])
                    2'd0:    core_data_o = {2'b00, kk_q};
                    2'd1:    core_data_o = {2'b00, nn_q};
                    2'd2:    core_data_o = ll_q[7:0];
                    default: core_data_o = ll_q[15:8];
                endcase
            end
            StBlock: begin
                core_data_o = s_data_i;
                core_ctrl_o = {blk_cmd, s_valid_i};
                s_ready_o   = s_valid_i & core_ready_i;
            end
            StPad:   core_ctrl_o = {blk_cmd, 1'b1};
            default: ;
        endcase
    end

    assign core_xfer = core_ctrl_o[0] & core_ready_i;
    assign hash_take = (state_q == StHash) & core_hash_v_i;

    // Whether the byte after the current transfer still comes from the source.
    assign byte_nxt     = {1'b0, byte_cnt_q} + 7'd1;
    assign msg_rem_nxt  = msg_rem_q - 16'((state_q == StBlock) && !key_blk_q);
    assign in_block_src = key_blk_q ? (byte_nxt < {1'b0, kk_q}) : (msg_rem_nxt != 16'd0);
    assign next_blk_src = msg_rem_nxt != 16'd0;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q    <= StIdle;
            kk_q       <= '0;
            nn_q       <= '0;
            ll_q       <= '0;
            byte_cnt_q <= '0;
            hash_cnt_q <= '0;
            blk_cnt_q  <= '0;
            msg_rem_q  <= '0;
            stall_q    <= '0;
            key_blk_q  <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            m_valid_q <= 1'b0;
            if (core_xfer || hash_take) stall_q <= '0;
            else                        stall_q <= stall_q + 16'd1;

            unique case (state_q)
                StIdle: begin
                    stall_q <= '0;
                    if (start_i) begin
                        if (bad_cfg) begin
                            err_q <= 1'b1;
                        end else begin
                            kk_q       <= key_len_i;
                            nn_q       <= hash_len_i;
                            ll_q       <= msg_len_i;
                            byte_cnt_q <= '0;
                            state_q    <= StCfg;
                        end
                    end
                end
                StCfg: begin
                    if (core_xfer) begin
                        if (byte_cnt_q == 6'd3) begin
                            byte_cnt_q <= '0;
                            blk_cnt_q  <= nb;
                            key_blk_q  <= kk_q != 6'd0;
                            msg_rem_q  <= ll_q;
                            state_q    <= (kk_q != 6'd0 || ll_q != 16'd0) ? StBlock : StPad;
                        end else begin
                            byte_cnt_q <= byte_nxt[5:0];
                        end
                    end
                end
                StBlock, StPad: begin
                    if (core_xfer) begin
                        byte_cnt_q <= byte_nxt[5:0];
                        msg_rem_q  <= msg_rem_nxt;
                        if (byte_cnt_q == 6'd63) begin
                            blk_cnt_q <= blk_cnt_q - 16'd1;
                            key_blk_q <= 1'b0;
                            if (blk_cnt_q == 16'd1) begin
                                hash_cnt_q <= '0;
                                state_q    <= StHash;
                            end else begin
                                state_q <= next_blk_src ? StBlock : StPad;
                            end
                        end else begin
                            state_q <= in_block_src ? StBlock : StPad;
                        end
                    end
                end
                StHash: begin
                    if (hash_take) begin
                        m_data_q   <= core_hash_i;
                        m_valid_q  <= 1'b1;
                        hash_cnt_q <= hash_cnt_q + 6'd1;
                        if (hash_cnt_q + 6'd1 == nn_q) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Stall watchdog overrides whatever the state wanted this cycle.
            if (state_q != StIdle && !core_xfer && !hash_take
                && stall_q == 16'(TIMEOUT - 1)) begin
                state_q <= StIdle;
                stall_q <= '0;
                done_q  <= 1'b0;
                err_q   <= 1'b1;
            end
        end
    end

    assign m_data_o  = m_data_q;
    assign m_valid_o = m_valid_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign busy_o    = state_q != StIdle;

endmodule

// File: tb/tb_hash_seq.sv
// Scoreboard bench for hash_seq: stimulus queues expected core/digest bytes,
// a negedge monitor pops and compares them as the DUT presents transfers.
module tb_hash_seq;

    logic        clk = 1'b0;
    logic        rst_async, start_i;
    logic [5:0]  key_len_i, hash_len_i;
    logic [15:0] msg_len_i;
    logic [7:0]  s_data_i;
    logic        s_valid_i, s_ready_o;
    logic [7:0]  core_data_o;
    logic [2:0]  core_ctrl_o;
    logic        core_ready_i, core_hash_v_i;
    logic [7:0]  core_hash_i, m_data_o;
    logic        m_valid_o, busy_o, done_o, err_o;

    hash_seq #(.MAX_LL(65535), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_async    (rst_async),
        .start_i      (start_i),
        .key_len_i    (key_len_i),
        .hash_len_i   (hash_len_i),
        .msg_len_i    (msg_len_i),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .core_data_o  (core_data_o),
        .core_ctrl_o  (core_ctrl_o),
        .core_ready_i (core_ready_i),
        .core_hash_v_i(core_hash_v_i),
        .core_hash_i  (core_hash_i),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [9:0] exp_core[$];
    logic [7:0] exp_dig[$];
    logic [7:0] src_bytes[$];
    logic [7:0] hash_bytes[$];
    int src_idx = 0, hidx = 0;
    bit src_fire = 0, hash_go = 0, gaps = 0, poke = 0;
    int xfer_cnt = 0, first_cnt = 0, done_cnt = 0, err_cnt = 0;
    int cyc = 0, last_xfer_cyc = 0, err_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Source, core-ready and hash-core models; inputs change 1ns after the edge.
    initial begin
        bit hold;
        s_valid_i = 0; s_data_i = 0; core_ready_i = 0; core_hash_v_i = 0; core_hash_i = 0;
        forever begin
            @(posedge clk); #1;
            hold = s_valid_i && !src_fire && (src_idx < src_bytes.size());
            if (src_fire) src_idx++;
            src_fire = 0;
            if (!hold) begin
                if (src_idx < src_bytes.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
                    s_valid_i = 1; s_data_i = src_bytes[src_idx];
                end else begin
                    s_valid_i = 0; s_data_i = 8'h00;
                end
            end
            core_ready_i = !gaps || ($urandom_range(0, 3) != 0);
            if (core_hash_v_i) hidx++;
            if (hash_go && hidx < hash_bytes.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
                core_hash_v_i = 1; core_hash_i = hash_bytes[hidx];
            end else begin
                core_hash_v_i = 0; core_hash_i = 8'h00;
            end
        end
    end

    // Monitor: pops the scoreboard on every core transfer and digest byte.
    initial begin
        logic [9:0] e;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            cyc++;
            if (core_ctrl_o[0] && core_ready_i) begin
                xfer_cnt++;
                last_xfer_cyc = cyc;
                if (core_ctrl_o[2:1] == 2'b01) first_cnt++;
                if (s_valid_i && s_ready_o) src_fire = 1;
                if (exp_core.size() == 0) begin
                    total++; bad++;
                    $display("FAIL core_extra: got %0h expected none", {core_ctrl_o[2:1], core_data_o});
                end else begin
                    e = exp_core.pop_front();
                    chk("core_byte", {core_ctrl_o[2:1], core_data_o}, e);
                    if (exp_core.size() == 0) hash_go = 1;
                end
            end
            if (m_valid_o) begin
                if (exp_dig.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dig_extra: got %0h expected none", m_data_o);
                end else begin
                    d = exp_dig.pop_front();
                    chk("digest_byte", m_data_o, d);
                end
            end
            if (done_o) done_cnt++;
            if (err_o) begin err_cnt++; err_cyc = cyc; end
        end
    end

    task automatic start_job(input int kk, input int nn, input int ll, input int nhash,
                             input bit g);
        int nb, m;
        logic [7:0] d;
        logic [1:0] c;
        exp_core.delete(); exp_dig.delete(); src_bytes.delete(); hash_bytes.delete();
        src_idx = 0; hidx = 0; src_fire = 0; hash_go = 0; gaps = g;
        xfer_cnt = 0; first_cnt = 0; done_cnt = 0; err_cnt = 0;
        for (int i = 0; i < kk; i++) src_bytes.push_back(8'(128 + i));
        for (int j = 0; j < ll; j++) src_bytes.push_back(8'(97 + j));   // "abc..."
        for (int i = 0; i < nhash; i++) begin
            hash_bytes.push_back(8'(195 ^ (i * 29)));
            if (i < nn) exp_dig.push_back(8'(195 ^ (i * 29)));
        end
        exp_core.push_back({2'b00, 8'(kk)});
        exp_core.push_back({2'b00, 8'(nn)});
        exp_core.push_back({2'b00, 8'(ll)});
        exp_core.push_back({2'b00, 8'(ll >> 8)});
        nb = (kk > 0 ? 1 : 0) + (ll + 63) / 64;
        if (nb == 0) nb = 1;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 64; i++) begin
                if (kk > 0 && b == 0) begin
                    d = (i < kk) ? src_bytes[i] : 8'h00;
                end else begin
                    m = (b - (kk > 0 ? 1 : 0)) * 64 + i;
                    d = (m < ll) ? src_bytes[kk + m] : 8'h00;
                end
                c = (i == 0) ? 2'b01 : ((b == nb - 1) ? 2'b11 : 2'b10);
                exp_core.push_back({c, d});
            end
        end
        @(posedge clk); #2;
        start_i = 1; key_len_i = 6'(kk); hash_len_i = 6'(nn); msg_len_i = 16'(ll);
        @(posedge clk); #2;
        start_i = 0;
    endtask

    task automatic finish_job(input int exp_done, input int exp_err);
        bit poked = 0;
        for (int i = 0; i < 4000 && (done_cnt + err_cnt) == 0; i++) begin
            @(posedge clk); #2;
            if (poke && hash_go && !poked) begin
                poked = 1;
                start_i = 1;
                @(posedge clk); #2;
                start_i = 0;
                chk("start_ignored_busy", busy_o, 1);
            end
        end
        repeat (12) @(posedge clk);
        #2;
        chk("done_pulses", done_cnt, exp_done);
        chk("err_pulses", err_cnt, exp_err);
        chk("core_left", exp_core.size(), 0);
        chk("dig_left", exp_dig.size(), 0);
        chk("idle_after", busy_o, 0);
        poke = 0;
    endtask

    task automatic bad_start(input int kk, input int nn, input int ll);
        @(posedge clk); #2;
        start_i = 1; key_len_i = 6'(kk); hash_len_i = 6'(nn); msg_len_i = 16'(ll);
        @(posedge clk); #2;
        start_i = 0;
        chk("bad_err", err_o, 1);
        chk("bad_busy", busy_o, 0);
        @(posedge clk); #2;
        chk("bad_err_clr", err_o, 0);
        chk("bad_no_cfg", core_ctrl_o[0], 0);
    endtask

    initial begin
        rst_async = 1; start_i = 0; key_len_i = 0; hash_len_i = 0; msg_len_i = 0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {core_ctrl_o, core_data_o, s_ready_o, m_valid_o, m_data_o,
                           busy_o, done_o, err_o}, 0);
        @(posedge clk); #2;
        rst_async = 0;

        // "abc", no key, 32-byte digest, extra hash bytes must be dropped.
        start_job(0, 32, 3, 34, 0);
        finish_job(1, 0);
        chk("abc_xfers", xfer_cnt, 68);
        chk("abc_firsts", first_cnt, 1);

        start_job(0, 1, 0, 3, 0);
        finish_job(1, 0);
        chk("empty_xfers", xfer_cnt, 68);
        chk("empty_firsts", first_cnt, 1);

        start_job(16, 20, 128, 22, 0);
        finish_job(1, 0);
        chk("key_xfers", xfer_cnt, 196);
        chk("key_firsts", first_cnt, 3);

        start_job(16, 20, 128, 22, 1);
        finish_job(1, 0);
        chk("gaps_xfers", xfer_cnt, 196);
        chk("gaps_firsts", first_cnt, 3);

        bad_start(33, 8, 4);
        bad_start(4, 0, 4);
        bad_start(4, 33, 4);

        // Core never returns a digest; a start issued in HASH must be ignored.
        start_job(0, 4, 3, 0, 0);
        poke = 1;
        finish_job(0, 1);
        chk("timeout_latency", err_cyc - last_xfer_cyc, 17);

        // Abort while byte 30 of the block is being presented.
        start_job(0, 8, 100, 10, 0);
        for (int i = 0; i < 500 && xfer_cnt < 34; i++) @(negedge clk);
        chk("reach_byte30", xfer_cnt, 34);
        @(posedge clk); #2;
        rst_async = 1;
        #1;
        chk("abort_outs", {core_ctrl_o, core_data_o, s_ready_o, m_valid_o, m_data_o,
                           busy_o, done_o, err_o}, 0);
        src_bytes.delete(); hash_bytes.delete(); exp_core.delete(); exp_dig.delete();
        hash_go = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_async = 0;
        repeat (5) @(posedge clk);
        #2;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_err", err_cnt, 0);

        start_job(0, 32, 3, 34, 0);
        finish_job(1, 0);
        chk("fresh_xfers", xfer_cnt, 68);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
